// File: rtl/mpc_pkg.sv
// Shared definitions for the multi-port cache: the burst-read state encoding
// and the default datapath widths common to the SRAM wrapper and its engines.
package mpc_pkg;

   localparam int DWIDTH_DEF    = 32;
   localparam int NRAMWIDTH_DEF = 5;
   localparam int AWIDTH_DEF    = 13;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } rd_state_e;

endpackage

// File: rtl/rd_fifo.sv
// Small synchronous FIFO with a combinational head: dout shows the oldest
// entry in the same cycle it becomes present. Pop on empty is ignored; the
// caller is responsible for never pushing while full.
module rd_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             pop_ok;

   assign empty  = (count_q == '0);
   assign full   = (count_q == CW'(DEPTH));
   assign count  = count_q;
   assign dout   = mem_q[rd_ptr_q];
   assign pop_ok = pop && !empty;

   // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state register; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset because occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/sram_rd_engine.sv
// Burst read engine: takes {start address, length}, issues one SRAM read per
// cycle under a credit limit, absorbs the one-cycle read latency and streams
// words out on valid/ready with a last marker.
// Optional feature macro: SRAM_RD_ENGINE_PERF_EN adds stall_cnt_out, a
// saturating count of output stall cycles cleared on each command handshake.
module sram_rd_engine
   import mpc_pkg::*;
#(
   parameter int DWIDTH     = DWIDTH_DEF,
   parameter int NRAMWIDTH  = NRAMWIDTH_DEF,
   parameter int AWIDTH     = AWIDTH_DEF,
   parameter int LWIDTH     = 9,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          cmd_valid_in,
   output logic                          cmd_ready_out,
   input  logic [NRAMWIDTH+AWIDTH-1:0]   cmd_addr_in,
   input  logic [LWIDTH-1:0]             cmd_len_in,
   output logic                          mem_en_out,
   output logic                          mem_we_out,
   output logic [NRAMWIDTH+AWIDTH-1:0]   mem_addr_out,
   output logic [DWIDTH-1:0]             mem_d_out,
   input  logic [DWIDTH-1:0]             mem_d_in,
   output logic                          out_valid_out,
   input  logic                          out_ready_in,
   output logic [DWIDTH-1:0]             out_data_out,
   output logic                          out_last_out,
   output logic                          busy_out
`ifdef SRAM_RD_ENGINE_PERF_EN
   ,
   output logic [31:0]                   stall_cnt_out
`endif
);

   localparam int MAW = NRAMWIDTH + AWIDTH;
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;

   rd_state_e         state_q, state_d;
   logic [MAW-1:0]    addr_q, addr_d;
   logic [LWIDTH-1:0] rem_q, rem_d;
   logic              inflight_q, inflight_d;
   logic              inflight_last_q, inflight_last_d;

   logic              cmd_fire;
   logic              credit_ok;
   logic [CW:0]       credit_used;

   logic              fifo_push;
   logic              fifo_pop;
   logic [DWIDTH:0]   fifo_din;
   logic [DWIDTH:0]   fifo_dout;
   logic [CW-1:0]     fifo_count;
   logic              fifo_empty;
   logic              fifo_full;

   // A read may issue only if its word is guaranteed a FIFO slot, counting the
   // word still in the SRAM pipeline; this keeps out_ready_in off the mem path.
   assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
   assign credit_ok   = (credit_used < (CW+1)'(FIFO_DEPTH));

   assign cmd_ready_out = (state_q == IDLE);
   assign busy_out      = (state_q != IDLE);
   assign cmd_fire      = cmd_valid_in && cmd_ready_out;
   assign mem_en_out    = (state_q == READ) && credit_ok;
   assign mem_addr_out  = addr_q;
   assign mem_we_out    = 1'b0;
   assign mem_d_out     = '0;

   assign fifo_push     = inflight_q;
   assign fifo_din      = {mem_d_in, inflight_last_q};
   assign out_valid_out = !fifo_empty;
   assign fifo_pop      = out_valid_out && out_ready_in;
   assign out_data_out  = out_valid_out ? fifo_dout[DWIDTH:1] : '0;
   assign out_last_out  = out_valid_out && fifo_dout[0];

   // Next-state logic: command capture, read issue and drain-to-idle.
   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      rem_d           = rem_q;
      inflight_d      = mem_en_out;
      inflight_last_d = mem_en_out && (rem_q == LWIDTH'(1));
      unique case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               addr_d = cmd_addr_in;
               rem_d  = cmd_len_in;
               if (cmd_len_in != '0) begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            if (mem_en_out) begin
               addr_d = addr_q + MAW'(1);
               rem_d  = rem_q - LWIDTH'(1);
               if (rem_q == LWIDTH'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (!inflight_q &&
                (fifo_empty || ((fifo_count == CW'(1)) && fifo_pop))) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset abandons any burst and drops data in flight.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         rem_q           <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         rem_q           <= rem_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
      end
   end

   // The credit rule must make a push into a full buffer impossible.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         assert (!(fifo_push && fifo_full));
      end
   end

   rd_fifo #(
      .WIDTH (DWIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_in),
      .srst  (rst_in),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

`ifdef SRAM_RD_ENGINE_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   assign stall_cnt_out = stall_cnt_q;

   // Saturating stall counter, restarted by each accepted command.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (cmd_fire) begin
         stall_cnt_d = '0;
      end else if (out_valid_out && !out_ready_in && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_sram_rd_engine.sv
// Directed bench for sram_rd_engine with a one-cycle-latency SRAM model whose
// word at address a is 32'hD000_0000 | a. Define SRAM_RD_ENGINE_PERF_EN to
// also exercise the stall counter.
module tb_sram_rd_engine;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        cmd_valid_in;
   logic        cmd_ready_out;
   logic [17:0] cmd_addr_in;
   logic [8:0]  cmd_len_in;
   logic        mem_en_out;
   logic        mem_we_out;
   logic [17:0] mem_addr_out;
   logic [31:0] mem_d_out;
   logic [31:0] mem_d_in = '0;
   logic        out_valid_out;
   logic        out_ready_in;
   logic [31:0] out_data_out;
   logic        out_last_out;
   logic        busy_out;
`ifdef SRAM_RD_ENGINE_PERF_EN
   logic [31:0] stall_cnt_out;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] beat_q[$];
   logic        beat_last_q[$];

   always #5 clk_in = ~clk_in;

   sram_rd_engine dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .cmd_valid_in  (cmd_valid_in),
      .cmd_ready_out (cmd_ready_out),
      .cmd_addr_in   (cmd_addr_in),
      .cmd_len_in    (cmd_len_in),
      .mem_en_out    (mem_en_out),
      .mem_we_out    (mem_we_out),
      .mem_addr_out  (mem_addr_out),
      .mem_d_out     (mem_d_out),
      .mem_d_in      (mem_d_in),
      .out_valid_out (out_valid_out),
      .out_ready_in  (out_ready_in),
      .out_data_out  (out_data_out),
      .out_last_out  (out_last_out),
      .busy_out      (busy_out)
`ifdef SRAM_RD_ENGINE_PERF_EN
      ,
      .stall_cnt_out (stall_cnt_out)
`endif
   );

   // SRAM model: registered read, one cycle after the enable.
   always @(posedge clk_in) begin
      if (mem_en_out) begin
         mem_d_in <= 32'hD000_0000 | {14'd0, mem_addr_out};
      end
   end

   // Beat monitor: values are stable mid-cycle, so record each handshake here.
   always @(negedge clk_in) begin
      if (!rst_in && out_valid_out && out_ready_in) begin
         beat_q.push_back(out_data_out);
         beat_last_q.push_back(out_last_out);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Advance one edge and check the cycle that follows it.
   task automatic step(input string tag, input logic en, input logic [17:0] addr,
                       input logic vld, input logic [31:0] data, input logic last,
                       input logic rdy);
      tick();
      chk({tag, ".en"}, {31'd0, mem_en_out}, {31'd0, en});
      if (en) chk({tag, ".addr"}, {14'd0, mem_addr_out}, {14'd0, addr});
      chk({tag, ".valid"}, {31'd0, out_valid_out}, {31'd0, vld});
      chk({tag, ".data"}, out_data_out, data);
      chk({tag, ".last"}, {31'd0, out_last_out}, {31'd0, last});
      chk({tag, ".cmd_ready"}, {31'd0, cmd_ready_out}, {31'd0, rdy});
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy_out && n < 100) begin
         tick();
         n++;
      end
      chk({tag, ".idle"}, {31'd0, busy_out}, 32'd0);
   endtask

   initial begin
      rst_in       = 1'b1;
      cmd_valid_in = 1'b0;
      cmd_addr_in  = '0;
      cmd_len_in   = '0;
      out_ready_in = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst.cmd_ready", {31'd0, cmd_ready_out}, 32'd1);
      chk("rst.busy", {31'd0, busy_out}, 32'd0);
      chk("rst.en", {31'd0, mem_en_out}, 32'd0);
      chk("rst.we", {31'd0, mem_we_out}, 32'd0);
      chk("rst.addr", {14'd0, mem_addr_out}, 32'd0);
      chk("rst.d_out", mem_d_out, 32'd0);
      chk("rst.valid", {31'd0, out_valid_out}, 32'd0);
      chk("rst.data", out_data_out, 32'd0);
      chk("rst.last", {31'd0, out_last_out}, 32'd0);
`ifdef SRAM_RD_ENGINE_PERF_EN
      chk("rst.stall", stall_cnt_out, 32'd0);
`endif
      rst_in = 1'b0;

      // Bank crossing: 0x01FFE, len 4
      out_ready_in = 1'b1;
      cmd_valid_in = 1'b1;
      cmd_addr_in  = 18'h01FFE;
      cmd_len_in   = 9'd4;
      step("bank1", 1'b1, 18'h01FFE, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("bank1.busy", {31'd0, busy_out}, 32'd1);
      cmd_valid_in = 1'b0;
      step("bank2", 1'b1, 18'h01FFF, 1'b0, 32'h0, 1'b0, 1'b0);
      step("bank3", 1'b1, 18'h02000, 1'b1, 32'hD0001FFE, 1'b0, 1'b0);
      chk("bank3.we", {31'd0, mem_we_out}, 32'd0);
      chk("bank3.d_out", mem_d_out, 32'd0);
      step("bank4", 1'b1, 18'h02001, 1'b1, 32'hD0001FFF, 1'b0, 1'b0);
      step("bank5", 1'b0, 18'h0, 1'b1, 32'hD0002000, 1'b0, 1'b0);
      step("bank6", 1'b0, 18'h0, 1'b1, 32'hD0002001, 1'b1, 1'b0);
      step("bank7", 1'b0, 18'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("bank7.busy", {31'd0, busy_out}, 32'd0);

      // Top-of-space wrap: 0x3FFFF, len 2
      cmd_valid_in = 1'b1;
      cmd_addr_in  = 18'h3FFFF;
      cmd_len_in   = 9'd2;
      step("wrap1", 1'b1, 18'h3FFFF, 1'b0, 32'h0, 1'b0, 1'b0);
      cmd_valid_in = 1'b0;
      step("wrap2", 1'b1, 18'h00000, 1'b0, 32'h0, 1'b0, 1'b0);
      step("wrap3", 1'b0, 18'h0, 1'b1, 32'hD003FFFF, 1'b0, 1'b0);
      step("wrap4", 1'b0, 18'h0, 1'b1, 32'hD0000000, 1'b1, 1'b0);
      step("wrap5", 1'b0, 18'h0, 1'b0, 32'h0, 1'b0, 1'b1);

      // Backpressure: len 16 at 0x100, ready low for cycles 3..10
      beat_q.delete();
      beat_last_q.delete();
      cmd_valid_in = 1'b1;
      cmd_addr_in  = 18'h00100;
      cmd_len_in   = 9'd16;
      step("bp1", 1'b1, 18'h00100, 1'b0, 32'h0, 1'b0, 1'b0);
      cmd_valid_in = 1'b0;
      step("bp2", 1'b1, 18'h00101, 1'b0, 32'h0, 1'b0, 1'b0);
      step("bp3", 1'b1, 18'h00102, 1'b1, 32'hD0000100, 1'b0, 1'b0);
      out_ready_in = 1'b0;
      step("bp4", 1'b1, 18'h00103, 1'b1, 32'hD0000100, 1'b0, 1'b0);
      for (int k = 5; k <= 11; k++) begin
         step($sformatf("bp%0d", k), 1'b0, 18'h0, 1'b1, 32'hD0000100, 1'b0, 1'b0);
      end
      out_ready_in = 1'b1;
      step("bp12", 1'b1, 18'h00104, 1'b1, 32'hD0000101, 1'b0, 1'b0);
      wait_idle("bp");
      chk("bp.nbeats", beat_q.size(), 32'd16);
      for (int i = 0; i < 16 && i < beat_q.size(); i++) begin
         chk($sformatf("bp.beat%0d", i), beat_q[i], 32'hD0000100 + i);
         chk($sformatf("bp.last%0d", i), {31'd0, beat_last_q[i]}, (i == 15) ? 32'd1 : 32'd0);
      end

      // Zero-length command
      beat_q.delete();
      beat_last_q.delete();
      cmd_valid_in = 1'b1;
      cmd_addr_in  = 18'h00055;
      cmd_len_in   = 9'd0;
      step("zero1", 1'b0, 18'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("zero1.busy", {31'd0, busy_out}, 32'd0);
      step("zero2", 1'b0, 18'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      cmd_valid_in = 1'b0;
      step("zero3", 1'b0, 18'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      step("zero4", 1'b0, 18'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("zero.nbeats", beat_q.size(), 32'd0);

      // Back-to-back: second command held valid during the first burst
      cmd_valid_in = 1'b1;
      cmd_addr_in  = 18'h00200;
      cmd_len_in   = 9'd3;
      step("bb1", 1'b1, 18'h00200, 1'b0, 32'h0, 1'b0, 1'b0);
      cmd_addr_in  = 18'h00300;
      cmd_len_in   = 9'd2;
      step("bb2", 1'b1, 18'h00201, 1'b0, 32'h0, 1'b0, 1'b0);
      step("bb3", 1'b1, 18'h00202, 1'b1, 32'hD0000200, 1'b0, 1'b0);
      step("bb4", 1'b0, 18'h0, 1'b1, 32'hD0000201, 1'b0, 1'b0);
      step("bb5", 1'b0, 18'h0, 1'b1, 32'hD0000202, 1'b1, 1'b0);
      step("bb6", 1'b0, 18'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      step("bb7", 1'b1, 18'h00300, 1'b0, 32'h0, 1'b0, 1'b0);
      cmd_valid_in = 1'b0;
      step("bb8", 1'b1, 18'h00301, 1'b0, 32'h0, 1'b0, 1'b0);
      step("bb9", 1'b0, 18'h0, 1'b1, 32'hD0000300, 1'b0, 1'b0);
      step("bb10", 1'b0, 18'h0, 1'b1, 32'hD0000301, 1'b1, 1'b0);
      step("bb11", 1'b0, 18'h0, 1'b0, 32'h0, 1'b0, 1'b1);

      // Reset at beat 3 of 8
      beat_q.delete();
      beat_last_q.delete();
      cmd_valid_in = 1'b1;
      cmd_addr_in  = 18'h00400;
      cmd_len_in   = 9'd8;
      step("rb1", 1'b1, 18'h00400, 1'b0, 32'h0, 1'b0, 1'b0);
      cmd_valid_in = 1'b0;
      step("rb2", 1'b1, 18'h00401, 1'b0, 32'h0, 1'b0, 1'b0);
      step("rb3", 1'b1, 18'h00402, 1'b1, 32'hD0000400, 1'b0, 1'b0);
      step("rb4", 1'b1, 18'h00403, 1'b1, 32'hD0000401, 1'b0, 1'b0);
      step("rb5", 1'b1, 18'h00404, 1'b1, 32'hD0000402, 1'b0, 1'b0);
      rst_in = 1'b1;
      step("rb6", 1'b0, 18'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("rb6.busy", {31'd0, busy_out}, 32'd0);
      chk("rb6.addr", {14'd0, mem_addr_out}, 32'd0);
      rst_in = 1'b0;
      for (int k = 7; k <= 10; k++) begin
         step($sformatf("rb%0d", k), 1'b0, 18'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      end
      chk("rb.nbeats", beat_q.size(), 32'd2);
      cmd_valid_in = 1'b1;
      cmd_addr_in  = 18'h00010;
      cmd_len_in   = 9'd1;
      step("nc1", 1'b1, 18'h00010, 1'b0, 32'h0, 1'b0, 1'b0);
      cmd_valid_in = 1'b0;
      step("nc2", 1'b0, 18'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      step("nc3", 1'b0, 18'h0, 1'b1, 32'hD0000010, 1'b1, 1'b0);
      step("nc4", 1'b0, 18'h0, 1'b0, 32'h0, 1'b0, 1'b1);

`ifdef SRAM_RD_ENGINE_PERF_EN
      // Stall counter: 5 stalled edges in one burst, then cleared by a handshake
      cmd_valid_in = 1'b1;
      cmd_addr_in  = 18'h00500;
      cmd_len_in   = 9'd4;
      step("pf1", 1'b1, 18'h00500, 1'b0, 32'h0, 1'b0, 1'b0);
      cmd_valid_in = 1'b0;
      step("pf2", 1'b1, 18'h00501, 1'b0, 32'h0, 1'b0, 1'b0);
      step("pf3", 1'b1, 18'h00502, 1'b1, 32'hD0000500, 1'b0, 1'b0);
      out_ready_in = 1'b0;
      repeat (5) tick();
      out_ready_in = 1'b1;
      wait_idle("pf");
      chk("pf.stall5", stall_cnt_out, 32'd5);
      cmd_valid_in = 1'b1;
      cmd_len_in   = 9'd0;
      tick();
      cmd_valid_in = 1'b0;
      chk("pf.stall_clr", stall_cnt_out, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
